// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the memory port arbiter:
//   - DEFAULT_AW / DEFAULT_DW : default address and data widths
//   - arb_state_t             : arbiter state encoding (IDLE, BUSY_IF, BUSY_DM)
package mem_port_arbiter_pkg;

  localparam int DEFAULT_AW = 32;
  localparam int DEFAULT_DW = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY_IF = 2'b01,
    BUSY_DM = 2'b10
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates one shared single-outstanding memory port between an
//   instruction-fetch requester (if_*) and a data requester (dm_*).
//   Data normally wins; fetch wins once it has watched IF_STARVE_MAX
//   consecutive data grants go by while waiting.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   if_req/if_addr -> if_gnt          fetch request, accepted by a 1-cycle gnt
//   if_rvalid/if_rdata                fetch return, 1 cycle after mem_ack
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata -> dm_gnt   data request
//   dm_rvalid/dm_rdata                data completion (reads and writes)
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata        shared memory command
//   mem_ack/mem_rdata                 memory completion and read data
//
// Grants are combinational in the arbitration cycle (IDLE, or the cycle of
// an accepted mem_ack), so a new command is latched on the same edge that
// retires the previous one and mem_req never dips between accesses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW            = DEFAULT_AW,
  parameter int DW            = DEFAULT_DW,
  parameter int IF_STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  // instruction fetch
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  // data access
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [DW/8-1:0] dm_be,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  output logic            dm_gnt,
  output logic            dm_rvalid,
  output logic [DW-1:0]   dm_rdata,
  // shared memory port
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int            CW         = $clog2(IF_STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(IF_STARVE_MAX);

  arb_state_t    state_q;
  arb_state_t    state_d;
  logic [CW-1:0] starve_cnt;

  logic ack_ok;
  logic arb_en;
  logic if_starved;
  logic grant_if;
  logic grant_dm;
  logic if_done;
  logic dm_done;

  // Arbitration stage: decide the winner in IDLE or in an accepted ack cycle.
  assign mem_req    = (state_q != IDLE);
  // An ack with no access outstanding is ignored entirely.
  assign ack_ok     = mem_req & mem_ack;
  assign arb_en     = (state_q == IDLE) | ack_ok;
  assign if_starved = if_req & (starve_cnt == STARVE_MAX);
  // rst_n gating keeps the combinational grants low while reset is held.
  assign grant_dm   = rst_n & arb_en & dm_req & ~if_starved;
  assign grant_if   = rst_n & arb_en & if_req & ~grant_dm;
  assign if_gnt     = grant_if;
  assign dm_gnt     = grant_dm;
  assign if_done    = ack_ok & (state_q == BUSY_IF);
  assign dm_done    = ack_ok & (state_q == BUSY_DM);

  always_comb begin
    state_d = state_q;
    if (grant_dm) begin
      state_d = BUSY_DM;
    end else if (grant_if) begin
      state_d = BUSY_IF;
    end else if (ack_ok) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Starvation counter: counts data grants taken while fetch is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!if_req || grant_if) begin
      starve_cnt <= '0;
    end else if (grant_dm && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Command stage: the winner's command is held stable until its ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_dm) begin
      mem_we    <= dm_we;
      mem_be    <= dm_be;
      mem_addr  <= dm_addr;
      mem_wdata <= dm_wdata;
    end else if (grant_if) begin
      mem_we    <= 1'b0;
      mem_be    <= '1;
      mem_addr  <= if_addr;
    end
  end

  // Return stage: capture mem_rdata on ack, pulse rvalid one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_rvalid <= if_done;
      dm_rvalid <= dm_done;
      if (if_done) begin
        if_rdata <= mem_rdata;
      end
      if (dm_done) begin
        dm_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed scenarios for reset, single read, collision, starvation,
//   reset during an access and stray acks, followed by a randomized run
//   checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int STARVE_MAX = 4;

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [3:0]    dm_be;
  logic [31:0]   dm_addr;
  logic [31:0]   dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [31:0]   dm_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [31:0]   mem_rdata;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .IF_STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic test_reset();
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h1000;
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'hF; dm_addr = 32'h2000; dm_wdata = 32'h1;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    @(negedge clk); #1;
    checks++; if (if_gnt !== 1'b0) begin failures++; $display("FAIL reset_if_gnt got=%b exp=0", if_gnt); end
    checks++; if (dm_gnt !== 1'b0) begin failures++; $display("FAIL reset_dm_gnt got=%b exp=0", dm_gnt); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if ({if_rvalid, dm_rvalid} !== 2'b00) begin failures++; $display("FAIL reset_rvalid got=%b exp=00", {if_rvalid, dm_rvalid}); end
    checks++; if ({mem_we, mem_be, mem_addr, mem_wdata} !== 69'd0) begin failures++; $display("FAIL reset_mem_cmd got=%h exp=0", {mem_we, mem_be, mem_addr, mem_wdata}); end
    checks++; if ({if_rdata, dm_rdata} !== 64'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", {if_rdata, dm_rdata}); end
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk); if_req = 1'b1; if_addr = 32'h0000_0040; #1;
    checks++; if ({if_gnt, dm_gnt} !== 2'b10) begin failures++; $display("FAIL single_gnt got=%b exp=10", {if_gnt, dm_gnt}); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL single_req_early got=%b exp=0", mem_req); end
    @(negedge clk); if_req = 1'b0; #1;
    checks++; if (if_gnt !== 1'b0) begin failures++; $display("FAIL single_gnt_pulse got=%b exp=0", if_gnt); end
    checks++; if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h40}) begin
      failures++; $display("FAIL single_cmd got=%h exp=%h", {mem_req, mem_we, mem_be, mem_addr}, {1'b1, 1'b0, 4'hF, 32'h40}); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++; if ({mem_req, if_rvalid} !== 2'b10) begin failures++; $display("FAIL single_wait got=%b exp=10", {mem_req, if_rvalid}); end
    end
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h2408_0005; #1;
    checks++; if ({mem_req, if_rvalid} !== 2'b10) begin failures++; $display("FAIL single_ack_cycle got=%b exp=10", {mem_req, if_rvalid}); end
    @(negedge clk); mem_ack = 1'b0; mem_rdata = 32'h0; #1;
    checks++; if (if_rvalid !== 1'b1) begin failures++; $display("FAIL single_rvalid got=%b exp=1", if_rvalid); end
    checks++; if (if_rdata !== 32'h2408_0005) begin failures++; $display("FAIL single_rdata got=%h exp=24080005", if_rdata); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", mem_req); end
    @(negedge clk); #1;
    checks++; if ({if_rvalid, if_rdata} !== {1'b0, 32'h2408_0005}) begin failures++; $display("FAIL single_hold got=%h exp=024080005", {if_rvalid, if_rdata}); end
  endtask

  task automatic test_collision();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_be = 4'h3; dm_wdata = 32'hDEAD_BEEF;
    #1;
    checks++; if ({if_gnt, dm_gnt} !== 2'b01) begin failures++; $display("FAIL coll_first got=%b exp=01", {if_gnt, dm_gnt}); end
    @(negedge clk); dm_req = 1'b0; #1;
    checks++; if ({if_gnt, dm_gnt} !== 2'b00) begin failures++; $display("FAIL coll_busy_gnt got=%b exp=00", {if_gnt, dm_gnt}); end
    checks++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL coll_dm_cmd got=%h exp=%h", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF}); end
    @(negedge clk); mem_ack = 1'b1; #1;
    checks++; if ({if_gnt, dm_gnt, mem_req} !== 3'b101) begin failures++; $display("FAIL coll_if_at_ack got=%b exp=101", {if_gnt, dm_gnt, mem_req}); end
    @(negedge clk); if_req = 1'b0; mem_ack = 1'b0; #1;
    checks++; if ({dm_rvalid, mem_req} !== 2'b11) begin failures++; $display("FAIL coll_no_gap got=%b exp=11", {dm_rvalid, mem_req}); end
    checks++; if ({mem_we, mem_be, mem_addr} !== {1'b0, 4'hF, 32'h200}) begin
      failures++; $display("FAIL coll_if_cmd got=%h exp=%h", {mem_we, mem_be, mem_addr}, {1'b0, 4'hF, 32'h200}); end
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h0000_1234; #1;
    @(negedge clk); mem_ack = 1'b0; #1;
    checks++; if ({if_rvalid, if_rdata, mem_req} !== {1'b1, 32'h1234, 1'b0}) begin
      failures++; $display("FAIL coll_if_ret got=%h exp=%h", {if_rvalid, if_rdata, mem_req}, {1'b1, 32'h1234, 1'b0}); end
  endtask

  task automatic test_starvation();
    bit exp_if;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if_req = 1'b1; if_addr = 32'h400;
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h300;
        mem_ack = 1'b1; mem_rdata = 32'h0;
      end
      if (i == 5) if_req = 1'b0;
      #1;
      exp_if = (i == 4);
      checks++; if ({if_gnt, dm_gnt} !== {exp_if, !exp_if}) begin
        failures++; $display("FAIL starve_grant_%0d got=%b exp=%b", i, {if_gnt, dm_gnt}, {exp_if, !exp_if}); end
      checks++; if (mem_req !== (i != 0)) begin failures++; $display("FAIL starve_mem_req_%0d got=%b exp=%b", i, mem_req, (i != 0)); end
    end
    @(negedge clk); dm_req = 1'b0; #1;
    checks++; if ({if_gnt, dm_gnt, mem_req, if_rvalid} !== 4'b0011) begin
      failures++; $display("FAIL starve_tail got=%b exp=0011", {if_gnt, dm_gnt, mem_req, if_rvalid}); end
    @(negedge clk); mem_ack = 1'b0; #1;
    checks++; if ({mem_req, dm_rvalid} !== 2'b01) begin failures++; $display("FAIL starve_end got=%b exp=01", {mem_req, dm_rvalid}); end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk); dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h80; #1;
    checks++; if (dm_gnt !== 1'b1) begin failures++; $display("FAIL rstmid_gnt got=%b exp=1", dm_gnt); end
    @(negedge clk); dm_req = 1'b0; #1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rstmid_busy got=%b exp=1", mem_req); end
    @(negedge clk); rst_n = 1'b0; dm_req = 1'b1; #1;
    checks++; if ({mem_req, dm_gnt, if_gnt, dm_rvalid, if_rvalid} !== 5'b0) begin
      failures++; $display("FAIL rstmid_ctrl got=%b exp=00000", {mem_req, dm_gnt, if_gnt, dm_rvalid, if_rvalid}); end
    checks++; if ({mem_we, mem_be, mem_addr, mem_wdata, if_rdata, dm_rdata} !== 133'd0) begin
      failures++; $display("FAIL rstmid_data got=%h exp=0", {mem_we, mem_be, mem_addr, mem_wdata, if_rdata, dm_rdata}); end
    @(negedge clk); dm_req = 1'b0; #1;
    checks++; if ({mem_req, dm_gnt, mem_addr} !== 34'd0) begin failures++; $display("FAIL rstmid_hold got=%h exp=0", {mem_req, dm_gnt, mem_addr}); end
    @(negedge clk); rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h99;
    dm_req = 1'b1; dm_addr = 32'h84; #1;
    checks++; if (dm_gnt !== 1'b1) begin failures++; $display("FAIL rstmid_first_gnt got=%b exp=1", dm_gnt); end
    @(negedge clk); dm_req = 1'b0; mem_ack = 1'b0; #1;
    checks++; if ({dm_rvalid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h84}) begin
      failures++; $display("FAIL rstmid_after got=%h exp=%h", {dm_rvalid, mem_req, mem_addr}, {1'b0, 1'b1, 32'h84}); end
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h55; #1;
    checks++; if (dm_rvalid !== 1'b0) begin failures++; $display("FAIL rstmid_no_rvalid got=%b exp=0", dm_rvalid); end
    @(negedge clk); mem_ack = 1'b0; #1;
    checks++; if ({dm_rvalid, dm_rdata} !== {1'b1, 32'h55}) begin failures++; $display("FAIL rstmid_ret got=%h exp=155", {dm_rvalid, dm_rdata}); end
  endtask

  task automatic test_stray_ack();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF; #1;
      checks++; if ({mem_req, if_rvalid, dm_rvalid} !== 3'b000) begin
        failures++; $display("FAIL stray_%0d got=%b exp=000", i, {mem_req, if_rvalid, dm_rvalid}); end
    end
    @(negedge clk); mem_ack = 1'b0; if_req = 1'b1; if_addr = 32'h44; #1;
    checks++; if ({if_rvalid, dm_rvalid, dm_rdata} !== {2'b00, 32'h55}) begin
      failures++; $display("FAIL stray_hold got=%h exp=055", {if_rvalid, dm_rvalid, dm_rdata}); end
    checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL stray_idle_gnt got=%b exp=1", if_gnt); end
    @(negedge clk); if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h7; #1;
    @(negedge clk); mem_ack = 1'b0; #1;
    checks++; if ({if_rvalid, if_rdata} !== {1'b1, 32'h7}) begin failures++; $display("FAIL stray_after got=%h exp=107", {if_rvalid, if_rdata}); end
  endtask

  // Reference model: tracks who owns the memory, the command it issued,
  // outstanding returns and the starvation count as plain variables.
  task automatic test_random();
    int          owner;   // 0 none, 1 fetch, 2 data
    int          starve;
    bit          can_arb, e_if, e_dm, prev_if, prev_dm;
    bit          exp_ifv, exp_dmv, dmd_known;
    logic [31:0] exp_ifd, exp_dmd, c_addr, c_wdata;
    logic        c_we;
    logic [3:0]  c_be;
    if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    owner = 0; starve = 0; prev_if = 0; prev_dm = 0;
    exp_ifv = 0; exp_dmv = 0; dmd_known = 1; exp_ifd = '0; exp_dmd = '0;
    c_addr = '0; c_wdata = '0; c_we = 1'b0; c_be = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (prev_if) if_req = 1'b0;
      if (prev_dm) dm_req = 1'b0;
      if (!if_req && $urandom_range(99) < 50) begin if_req = 1'b1; if_addr = $urandom; end
      if (!dm_req && $urandom_range(99) < 75) begin
        dm_req = 1'b1; dm_we = 1'($urandom_range(1)); dm_be = 4'($urandom_range(15));
        dm_addr = $urandom; dm_wdata = $urandom;
      end
      mem_ack = ($urandom_range(99) < 50);
      mem_rdata = $urandom;
      #1;
      can_arb = (owner == 0) || mem_ack;
      e_dm = can_arb && dm_req && !(if_req && starve == STARVE_MAX);
      e_if = can_arb && if_req && !e_dm;
      checks++; if ({if_gnt, dm_gnt} !== {e_if, e_dm}) begin
        failures++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, {if_gnt, dm_gnt}, {e_if, e_dm}); end
      checks++; if (mem_req !== (owner != 0)) begin
        failures++; $display("FAIL rnd_mem_req cyc=%0d got=%b exp=%b", cyc, mem_req, (owner != 0)); end
      if (owner != 0) begin
        checks++; if ({mem_we, mem_be, mem_addr} !== {c_we, c_be, c_addr}) begin
          failures++; $display("FAIL rnd_cmd cyc=%0d got=%h exp=%h", cyc, {mem_we, mem_be, mem_addr}, {c_we, c_be, c_addr}); end
        if (c_we) begin
          checks++; if (mem_wdata !== c_wdata) begin failures++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, mem_wdata, c_wdata); end
        end
      end
      checks++; if ({if_rvalid, dm_rvalid} !== {exp_ifv, exp_dmv}) begin
        failures++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, {if_rvalid, dm_rvalid}, {exp_ifv, exp_dmv}); end
      checks++; if (if_rdata !== exp_ifd) begin failures++; $display("FAIL rnd_if_rdata cyc=%0d got=%h exp=%h", cyc, if_rdata, exp_ifd); end
      if (dmd_known) begin
        checks++; if (dm_rdata !== exp_dmd) begin failures++; $display("FAIL rnd_dm_rdata cyc=%0d got=%h exp=%h", cyc, dm_rdata, exp_dmd); end
      end
      exp_ifv = 0; exp_dmv = 0;
      if (mem_ack && owner == 1) begin exp_ifv = 1; exp_ifd = mem_rdata; end
      if (mem_ack && owner == 2) begin
        exp_dmv = 1;
        if (c_we) dmd_known = 0;
        else begin dmd_known = 1; exp_dmd = mem_rdata; end
      end
      if (e_dm) begin
        owner = 2; c_addr = dm_addr; c_we = dm_we; c_be = dm_be; c_wdata = dm_wdata;
      end else if (e_if) begin
        owner = 1; c_addr = if_addr; c_we = 1'b0; c_be = 4'hF;
      end else if (mem_ack) begin
        owner = 0;
      end
      if (!if_req || e_if) starve = 0;
      else if (e_dm && starve < STARVE_MAX) starve++;
      prev_if = e_if; prev_dm = e_dm;
    end
    if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_collision();
    test_starvation();
    test_reset_mid_access();
    test_stray_ack();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits; byte-enable width is DW/8.
REQ-003 Parameter IF_STARVE_MAX, default 4, maximum consecutive data grants while instruction fetch waits.
REQ-004 Ports SHALL be as follows (clock and reset first):
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DW  fetch read data
- dm_req  in  1  data request; held until dm_gnt
- dm_we  in  1  1 = write, 0 = read
- dm_be  in  DW/8  byte enables
- dm_addr  in  AW  data address
- dm_wdata  in  DW  write data
- dm_gnt  out  1  one-cycle pulse: data request accepted
- dm_rvalid  out  1  one-cycle pulse: data access complete; dm_rdata valid for reads
- dm_rdata  out  DW  data read data
- mem_req  out  1  shared memory port request
- mem_we, mem_be, mem_addr, mem_wdata  out  1, DW/8, AW, DW  latched command
- mem_ack  in  1  memory completes the access this cycle
- mem_rdata  in  DW  valid when mem_ack = 1

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, BUSY_IF, BUSY_DM.
REQ-006 Winner selection in IDLE: dm_req wins, unless if_req=1 and starve_cnt == IF_STARVE_MAX, in which case if_req wins.
REQ-007 On a grant: assert the winner's gnt for exactly one cycle; latch its command into the mem_* registers; go to BUSY_IF or BUSY_DM; assert mem_req from the next cycle.
REQ-008 Fetch commands SHALL be latched as mem_we=0, mem_be=all ones.
REQ-009 In BUSY_*, mem_req and all mem_* command outputs SHALL stay stable until the cycle mem_ack=1.
REQ-010 In the mem_ack cycle, mem_rdata SHALL be registered into the owner's rdata; the owner's rvalid pulses the following cycle, giving a fixed 1-cycle return latency after ack.
REQ-011 A write SHALL still produce a dm_rvalid completion pulse; dm_rdata is then undefined but stable.
REQ-012 Back-to-back: in the mem_ack cycle the arbiter SHALL apply REQ-006 to pending requests and grant in that same cycle, so mem_req stays high with no idle cycle.
REQ-013 With no request pending at ack, the FSM SHALL go to IDLE and mem_req SHALL be 0 the next cycle.
REQ-014 starve_cnt is saturating at IF_STARVE_MAX:
- increments on each dm grant while if_req=1
- clears on any if grant or when if_req=0
REQ-015 Simultaneous if_req and dm_req SHALL grant exactly one requester per arbitration; gnt never goes to both.
REQ-016 Requests arriving in BUSY_* SHALL neither be granted nor lost; they are serviced per REQ-012 or REQ-006.
REQ-017 A mem_ack while mem_req=0 SHALL be ignored.
REQ-018 rdata outputs SHALL hold their last value between rvalid pulses.

Reset
REQ-019 With rst_n=0, asynchronously: state=IDLE; mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid = 0; mem_* command, if_rdata, dm_rdata = 0; starve_cnt=0.
REQ-020 Reset during BUSY_* SHALL abort the access; no rvalid is issued for it after reset release.
REQ-021 The first grant SHALL be possible in the first rising edge with rst_n=1.

Structure
REQ-022 The state encoding enum and the default AW/DW values SHALL live in the shared core package.
REQ-023 The block SHALL be one flat module with no sub-modules; the command latch is a plain register set.

Verification
REQ-024 Single read: if_req, if_addr=0x0000_0040; mem_ack 3 cycles after mem_req with rdata 0x2408_0005 -> if_gnt 1 pulse; mem_addr=0x40, mem_we=0, mem_be=0xF; if_rvalid with 0x2408_0005 one cycle after ack.
REQ-025 Collision: if_req and dm_req (write, addr 0x100, be 0x3, wdata 0xDEAD_BEEF) rise in the same cycle -> dm_gnt first; mem_we=1, mem_be=0x3; if_gnt at the dm ack cycle; mem_req never drops.
REQ-026 Starvation: dm_req held high with if_req high, ack after 1 cycle each -> exactly 4 dm grants, then 1 if grant, then dm again.
REQ-027 Reset mid-access: rst_n low 2 cycles while in BUSY_DM; mem_ack given after release -> all outputs 0 during reset; no dm_rvalid; next grant normal.
REQ-028 Stray ack: mem_ack=1 in IDLE with no requests -> no rvalid; state stays IDLE.
